// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision FP arithmetic units.
package fp_pkg;

    localparam int unsigned EXP_W     = 8;
    localparam int unsigned MAN_W     = 23;
    localparam int unsigned BIAS      = 127;
    localparam logic [31:0] QNAN      = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF   = 32'h7F80_0000;
    localparam int unsigned DIV_ITERS = 26;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StDiv,
        StNorm,
        StDone
    } state_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp_mant_div.sv
// Restoring mantissa divider: one quotient bit per step, MSB (weight 2^0) first.
module fp_mant_div #(
    parameter int unsigned MAN_W = fp_pkg::MAN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [MAN_W:0]     ma,
    input  logic [MAN_W:0]     mb,
    output logic [MAN_W+2:0]   quo,
    output logic               last
);
    import fp_pkg::*;

    localparam int unsigned RW = MAN_W + 3;
    localparam int unsigned CW = $clog2(DIV_ITERS);

    logic [RW-1:0] rem_q, rem_d;
    logic [RW-1:0] quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] mb_ext;
    logic [RW-1:0] diff;
    logic          ge;

    always_comb begin
        mb_ext = {2'b00, mb};
        ge     = (rem_q >= mb_ext);
        diff   = ge ? (rem_q - mb_ext) : rem_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        if (load) begin
            rem_d = {2'b00, ma};
            quo_d = '0;
            cnt_d = '0;
        end else if (step) begin
            // Remainder stays below 2*mb, so the shifted value always fits.
            rem_d = {diff[RW-2:0], 1'b0};
            quo_d = {quo_q[RW-2:0], ge};
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
        end
    end

    assign quo  = quo_q;
    assign last = (cnt_q == CW'(DIV_ITERS - 1));

endmodule

// File: rtl/fp_divider.sv
// Sequential IEEE-754 single-precision divider, round-toward-zero, start/done handshake.
module fp_divider #(
    parameter int unsigned EXP_W = fp_pkg::EXP_W,
    parameter int unsigned MAN_W = fp_pkg::MAN_W,
    parameter int unsigned BIAS  = fp_pkg::BIAS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        done
);
    import fp_pkg::*;

    localparam int unsigned EW      = EXP_W + 2;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

    state_e            state_q, state_d;
    logic [31:0]       a_q, b_q;
    logic [31:0]       res_q, res_d, result_q;
    logic              done_q;
    logic              latch, load, step, res_en, last;
    fp32_t             fa, fb;
    logic              sign;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic              is_spec;
    logic [31:0]       spec_res, norm_res;
    logic [MAN_W+2:0]  quo;
    logic signed [EW-1:0] exp_e, exp_n;
    logic [MAN_W-1:0]  frac_n;
    logic              unused_sticky;

    assign fa   = a_q;
    assign fb   = b_q;
    assign sign = fa.sign ^ fb.sign;

    // Zero exponent covers denormals, which are flushed to signed zero.
    assign a_zero = (fa.exp == '0);
    assign b_zero = (fb.exp == '0);
    assign a_inf  = (&fa.exp) && (fa.frac == '0);
    assign b_inf  = (&fb.exp) && (fb.frac == '0);
    assign a_nan  = (&fa.exp) && (fa.frac != '0);
    assign b_nan  = (&fb.exp) && (fb.frac != '0);

    always_comb begin
        is_spec  = 1'b1;
        spec_res = QNAN;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = QNAN;
        end else if (b_zero || a_inf) begin
            spec_res = POS_INF | {sign, 31'b0};
        end else if (a_zero || b_inf) begin
            spec_res = {sign, 31'b0};
        end else begin
            is_spec = 1'b0;
        end
    end

    assign exp_e = $signed({2'b00, fa.exp} - {2'b00, fb.exp} + EW'(BIAS));

    always_comb begin
        if (quo[MAN_W+2]) begin
            frac_n = quo[MAN_W+1 -: MAN_W];
            exp_n  = exp_e;
        end else begin
            frac_n = quo[MAN_W -: MAN_W];
            exp_n  = $signed(exp_e - EW'(1));
        end
        if (exp_n >= $signed(EW'(EXP_MAX))) begin
            norm_res = POS_INF | {sign, 31'b0};
        end else if (exp_n <= $signed(EW'(0))) begin
            norm_res = {sign, 31'b0};
        end else begin
            norm_res = {sign, exp_n[EXP_W-1:0], frac_n};
        end
    end

    assign unused_sticky = quo[0];

    fp_mant_div #(
        .MAN_W (MAN_W)
    ) u_mant_div (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .ma   ({1'b1, fa.frac}),
        .mb   ({1'b1, fb.frac}),
        .quo  (quo),
        .last (last)
    );

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        res_en  = 1'b0;
        res_d   = res_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    latch   = 1'b1;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (is_spec) begin
                    res_en  = 1'b1;
                    res_d   = spec_res;
                    state_d = StDone;
                end else begin
                    load    = 1'b1;
                    state_d = StDiv;
                end
            end
            StDiv: begin
                step = 1'b1;
                if (last) begin
                    state_d = StNorm;
                end
            end
            StNorm: begin
                res_en  = 1'b1;
                res_d   = norm_res;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Result and done update together so result never changes ahead of the pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                a_q <= a;
                b_q <= b;
            end
            if (res_en) begin
                res_q <= res_d;
            end
            done_q <= (state_q == StDone);
            if (state_q == StDone) begin
                result_q <= res_q;
            end
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_fp_divider.sv
// Directed scoreboard bench for fp_divider: results, latency, reset abort, start handling.
module tb_fp_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic [31:0] result;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] sb_exp[$];
    bit          sb_tol[$];
    string       sb_tag[$];

    always #5 clk = ~clk;

    fp_divider dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .result (result),
        .done   (done)
    );

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        bit          t;
        string       tag;
        bit          ok;
        if (rst === 1'b1 && done === 1'b1) begin
            n_cmp++;
            assert (sb_exp.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_done: observed result %h, required no done pulse", result);
            end
            if (sb_exp.size() != 0) begin
                e   = sb_exp.pop_front();
                t   = sb_tol.pop_front();
                tag = sb_tag.pop_front();
                ok  = (result === e) || (t && (result === e - 32'd1));
                n_cmp++;
                assert (ok) else begin
                    n_fail++;
                    $error("FAIL %s: observed %h required %h", tag, result, e);
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] e, input bit t, input string tag);
        sb_exp.push_back(e);
        sb_tol.push_back(t);
        sb_tag.push_back(tag);
    endtask

    task automatic check_int(input int obs, input int exp, input string tag);
        n_cmp++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1 with the FSM idle.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] e,
                          input bit t, input int lat, input string tag);
        int got;
        got   = -1;
        a     = ia;
        b     = ib;
        start = 1'b1;
        push_exp(e, t, tag);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (k == 0) start = 1'b0;
            if (done === 1'b1) begin
                got = k;
                break;
            end
        end
        check_int(got, lat, {tag, "_latency"});
        if (got < 0) begin
            sb_exp.delete();
            sb_tol.delete();
            sb_tag.delete();
        end
        @(posedge clk); #1;
        check_int(int'(done), 0, {tag, "_pulse_width"});
    endtask

    task automatic expect_quiet(input string tag);
        int cnt;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) cnt++;
        end
        check_int(cnt, 0, tag);
    endtask

    initial begin
        int got;
        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        assert (result === 32'h0000_0000) else begin
            n_fail++;
            $error("FAIL reset_result: observed %h required %h", result, 32'h0);
        end
        check_int(int'(done), 0, "reset_done");
        rst = 1'b1;
        @(posedge clk); #1;

        run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 29, "div_6_2");
        run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 29, "div_1_3");
        run_op(32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, 1'b0, 29, "div_m7p5_2p5");
        run_op(32'hC4B5_6AF7, 32'h416C_A3D7, 32'hC2C4_428F, 1'b1, 29, "div_big");
        run_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 2, "one_div_zero");
        run_op(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b0, 2, "neg_div_zero");
        run_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 2, "zero_div_zero");
        run_op(32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 1'b0, 2, "zero_div_five");
        run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 2, "nan_operand");
        run_op(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0, 2, "inf_div_inf");
        run_op(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 1'b0, 2, "inf_div_fin");
        run_op(32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 1'b0, 2, "fin_div_inf");
        run_op(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0, 2, "denorm_num");
        run_op(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 1'b0, 29, "overflow");
        run_op(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 29, "underflow");
        run_op(32'h3F80_0000, 32'h0000_0001, 32'h7F80_0000, 1'b0, 2, "denorm_den");

        // Abort mid-division: result and done clear at once, no pulse follows.
        a     = 32'h40C0_0000;
        b     = 32'h4000_0000;
        start = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 0) start = 1'b0;
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        assert (result === 32'h0000_0000) else begin
            n_fail++;
            $error("FAIL abort_result: observed %h required %h", result, 32'h0);
        end
        check_int(int'(done), 0, "abort_done");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        expect_quiet("abort_no_done");
        run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 29, "after_abort");

        // Start toggled while busy is ignored.
        got   = -1;
        a     = 32'h40C0_0000;
        b     = 32'h4000_0000;
        start = 1'b1;
        push_exp(32'h4040_0000, 1'b0, "toggle_first");
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (k == 0) start = 1'b0;
            if (k >= 4 && k <= 12) begin
                start = k[0];
                a     = 32'h3F80_0000;
                b     = 32'h4040_0000;
            end
            if (k == 13) start = 1'b0;
            if (done === 1'b1) begin
                got = k;
                break;
            end
        end
        start = 1'b0;
        check_int(got, 29, "toggle_latency");
        expect_quiet("toggle_no_extra");

        // Start held high: back-to-back operations 30 edges apart.
        a     = 32'h3F80_0000;
        b     = 32'h4040_0000;
        start = 1'b1;
        push_exp(32'h3EAA_AAAA, 1'b0, "b2b_first");
        push_exp(32'h3EAA_AAAA, 1'b0, "b2b_second");
        got = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                got = k;
                break;
            end
        end
        check_int(got, 29, "b2b_first_latency");
        got = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                got   = k + 1;
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        check_int(got, 30, "b2b_spacing");
        @(posedge clk); #1;
        check_int(int'(done), 0, "b2b_pulse_width");
        expect_quiet("b2b_stops");
        check_int(sb_exp.size(), 0, "scoreboard_drained");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
